// File: rtl/m68k_bus_queue.sv
// Queued 68000 bus master: posted requests are split into 16-bit bus cycles
// timed on CLK_7M edge strobes, one response per request through a FIFO.
module m68k_bus_queue #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned REQ_DEPTH   = 4,
  parameter int unsigned RSP_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              mc_rise,
  input  logic              mc_fall,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_read,
  input  logic [2:0]        req_fc,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_status,
  output logic              busy,
  input  logic              nDTACK,
  input  logic              nBERR,
  input  logic [15:0]       D_IN,
  output logic [ADDR_W-2:0] A_OUT,
  output logic [2:0]        FC_OUT,
  output logic [15:0]       D_OUT,
  output logic              a_oe,
  output logic              d_oe,
  output logic              as_n,
  output logic              uds_n,
  output logic              lds_n,
  output logic              rw
);
  localparam int unsigned QAW = $clog2(REQ_DEPTH);
  localparam int unsigned SAW = $clog2(RSP_DEPTH);
  localparam logic [QAW:0] REQ_FULL = (QAW+1)'(REQ_DEPTH);
  localparam logic [SAW:0] RSP_FULL = (SAW+1)'(RSP_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ASSERT, S_WDATA, S_WAIT, S_TERM, S_NEG, S_RELEASE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic              read;
    logic [2:0]        fc;
    logic [31:0]       wdata;
  } req_t;

  req_t        req_mem [REQ_DEPTH];
  logic [33:0] rsp_mem [RSP_DEPTH];

  logic [QAW-1:0] req_wp_q, req_wp_d, req_rp_q, req_rp_d;
  logic [QAW:0]   req_cnt_q, req_cnt_d;
  logic [SAW-1:0] rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
  logic [SAW:0]   rsp_cnt_q, rsp_cnt_d;
  logic           rdy_q, rdy_d;
  logic [17:0]    s1_q, s1_d, s2_q, s2_d;

  state_t            state_q, state_d;
  logic              word2_q, word2_d;
  logic [1:0]        status_q, status_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-2:0] a_out_q, a_out_d;
  logic [2:0]        fc_out_q, fc_out_d;
  logic [15:0]       d_out_q, d_out_d;
  logic              a_oe_q, a_oe_d, d_oe_q, d_oe_d, rw_q, rw_d;
  logic              as_n_q, as_n_d, uds_n_q, uds_n_d, lds_n_q, lds_n_d;

  logic              req_push, req_pop, rsp_push, rsp_pop, req_empty, rsp_full;
  logic              launch, launch_w2, sample, berr_s, dtack_s;
  logic              is_byte, is_long, misaligned, lane_u, lane_l;
  logic [ADDR_W-1:0] addr_lo, nxt_addr;
  logic [31:0]       cnt_inc, rd_merge;
  logic [33:0]       rsp_in;
  logic [15:0]       wr_word, d_s;
  req_t              head;

  assign head       = req_mem[req_rp_q];
  assign req_empty  = (req_cnt_q == '0);
  assign rsp_full   = (rsp_cnt_q == RSP_FULL);
  assign req_ready  = rdy_q & (req_cnt_q != REQ_FULL);
  assign req_push   = req_valid & req_ready;
  assign rsp_valid  = (rsp_cnt_q != '0);
  assign rsp_pop    = rsp_valid & rsp_ready;
  assign {rsp_rdata, rsp_status} = rsp_mem[rsp_rp_q];
  assign {berr_s, dtack_s, d_s}  = s2_q;

  assign is_byte    = ~head.size[1];
  assign is_long    = (head.size == 2'd3);
  assign misaligned = head.size[1] & head.addr[0];
  assign lane_u     = ~is_byte | ~head.addr[0];
  assign lane_l     = ~is_byte | head.addr[0];
  assign addr_lo    = head.addr + ADDR_W'(2);

  always_comb begin
    s1_d      = {nBERR, nDTACK, D_IN};
    s2_d      = s1_q;
    rdy_d     = 1'b1;
    req_wp_d  = req_push ? req_wp_q + 1'b1 : req_wp_q;
    req_rp_d  = req_pop  ? req_rp_q + 1'b1 : req_rp_q;
    req_cnt_d = req_cnt_q + (QAW+1)'(req_push) - (QAW+1)'(req_pop);
    rsp_wp_d  = rsp_push ? rsp_wp_q + 1'b1 : rsp_wp_q;
    rsp_rp_d  = rsp_pop  ? rsp_rp_q + 1'b1 : rsp_rp_q;
    rsp_cnt_d = rsp_cnt_q + (SAW+1)'(rsp_push) - (SAW+1)'(rsp_pop);
  end

  always_comb begin
    if (is_long)      wr_word = word2_q ? head.wdata[15:0] : head.wdata[31:16];
    else if (is_byte) wr_word = {head.wdata[7:0], head.wdata[7:0]};
    else              wr_word = head.wdata[15:0];
    if (is_byte)      rd_merge = {24'h0, head.addr[0] ? d_s[7:0] : d_s[15:8]};
    else if (is_long) rd_merge = word2_q ? {rdata_q[31:16], d_s} : {d_s, rdata_q[15:0]};
    else              rd_merge = {16'h0, d_s};
  end

  always_comb begin
    state_d = state_q;   word2_d = word2_q;   status_d = status_q;
    rdata_d = rdata_q;   wait_cnt_d = wait_cnt_q;
    a_out_d = a_out_q;   fc_out_d = fc_out_q; d_out_d = d_out_q;
    a_oe_d  = a_oe_q;    d_oe_d = d_oe_q;     rw_d = rw_q;
    as_n_d  = as_n_q;    uds_n_d = uds_n_q;   lds_n_d = lds_n_q;
    launch  = 1'b0;      launch_w2 = 1'b0;    sample = 1'b0;
    cnt_inc = wait_cnt_q + 32'd1;
    rsp_push = 1'b0;     req_pop = 1'b0;      rsp_in = '0;
    nxt_addr = head.addr;
    case (state_q)
      S_IDLE: if (!req_empty && !rsp_full) begin
        if (misaligned) begin
          rsp_push = 1'b1;
          rsp_in   = {32'h0, 2'd3};
          req_pop  = 1'b1;
        end else if (mc_rise) begin
          launch = 1'b1;
        end
      end
      S_ADDR: if (mc_fall) begin
        as_n_d = 1'b0;
        if (rw_q) begin
          uds_n_d = ~lane_u;
          lds_n_d = ~lane_l;
        end
        state_d = S_ASSERT;
      end
      S_ASSERT: if (mc_rise) begin
        if (!rw_q) begin
          d_out_d = wr_word;
          d_oe_d  = 1'b1;
        end
        state_d = S_WDATA;
      end
      S_WDATA: if (mc_fall) begin
        if (!rw_q) begin
          uds_n_d = ~lane_u;
          lds_n_d = ~lane_l;
        end
        sample  = 1'b1;
        cnt_inc = 32'd1;
      end
      S_WAIT: if (mc_fall) sample = 1'b1;
      S_TERM: if (mc_fall) begin
        as_n_d  = 1'b1;
        uds_n_d = 1'b1;
        lds_n_d = 1'b1;
        if (rw_q && status_q == 2'd0) rdata_d = rd_merge;
        state_d = S_NEG;
      end
      S_NEG: if (mc_rise) begin
        d_oe_d  = 1'b0;
        a_oe_d  = 1'b0;
        rw_d    = 1'b1;
        state_d = S_RELEASE;
      end
      S_RELEASE: if (mc_rise) begin
        if (is_long && !word2_q && status_q == 2'd0) begin
          launch    = 1'b1;
          launch_w2 = 1'b1;
        end else begin
          rsp_push = 1'b1;
          rsp_in   = {(status_q == 2'd0) ? rdata_q : 32'h0, status_q};
          req_pop  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // The mc_fall that enters WAIT is itself the first termination sample.
    if (sample) begin
      wait_cnt_d = cnt_inc;
      if (!berr_s) begin
        state_d = S_TERM; status_d = 2'd1;
      end else if (!dtack_s) begin
        state_d = S_TERM; status_d = 2'd0;
      end else if (TIMEOUT_CYC != 0 && cnt_inc == TIMEOUT_CYC) begin
        state_d = S_TERM; status_d = 2'd2;
      end else begin
        state_d = S_WAIT;
      end
    end
    if (launch) begin
      state_d  = S_ADDR;
      word2_d  = launch_w2;
      nxt_addr = launch_w2 ? addr_lo : head.addr;
      a_out_d  = nxt_addr[ADDR_W-1:1];
      fc_out_d = head.fc;
      rw_d     = head.read;
      a_oe_d   = 1'b1;
      status_d = 2'd0;
      if (!launch_w2) rdata_d = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (req_push) req_mem[req_wp_q] <= {req_addr, req_size, req_read, req_fc, req_wdata};
    if (rsp_push) rsp_mem[rsp_wp_q] <= rsp_in;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_wp_q <= '0; req_rp_q <= '0; req_cnt_q <= '0;
      rsp_wp_q <= '0; rsp_rp_q <= '0; rsp_cnt_q <= '0;
      rdy_q    <= 1'b0;
      s1_q     <= 18'h30000;
      s2_q     <= 18'h30000;
      state_q  <= S_IDLE;
      word2_q  <= 1'b0;  status_q <= '0; rdata_q <= '0; wait_cnt_q <= '0;
      a_out_q  <= '0;    fc_out_q <= '0; d_out_q <= '0;
      a_oe_q   <= 1'b0;  d_oe_q <= 1'b0; rw_q <= 1'b1;
      as_n_q   <= 1'b1;  uds_n_q <= 1'b1; lds_n_q <= 1'b1;
    end else begin
      req_wp_q <= req_wp_d; req_rp_q <= req_rp_d; req_cnt_q <= req_cnt_d;
      rsp_wp_q <= rsp_wp_d; rsp_rp_q <= rsp_rp_d; rsp_cnt_q <= rsp_cnt_d;
      rdy_q    <= rdy_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      state_q  <= state_d;
      word2_q  <= word2_d; status_q <= status_d; rdata_q <= rdata_d; wait_cnt_q <= wait_cnt_d;
      a_out_q  <= a_out_d; fc_out_q <= fc_out_d; d_out_q <= d_out_d;
      a_oe_q   <= a_oe_d;  d_oe_q <= d_oe_d;   rw_q <= rw_d;
      as_n_q   <= as_n_d;  uds_n_q <= uds_n_d; lds_n_q <= lds_n_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign A_OUT  = a_out_q;
  assign FC_OUT = fc_out_q;
  assign D_OUT  = d_out_q;
  assign a_oe   = a_oe_q;
  assign d_oe   = d_oe_q;
  assign rw     = rw_q;
  assign as_n   = as_n_q;
  assign uds_n  = uds_n_q;
  assign lds_n  = lds_n_q;
endmodule

// File: tb/tb_m68k_bus_queue.sv
// Directed bench for m68k_bus_queue: vector table of single requests plus
// backpressure and mid-cycle reset sequences.
module tb_m68k_bus_queue;
  logic        sys_clk = 1'b0, sys_rst_n = 1'b1, mc_rise = 1'b0, mc_fall = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_read = 1'b0;
  logic [23:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [2:0]  req_fc = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        nDTACK = 1'b1, nBERR = 1'b1;
  logic [15:0] D_IN = '0, D_OUT;
  logic [22:0] A_OUT;
  logic [2:0]  FC_OUT;
  logic        a_oe, d_oe, as_n, uds_n, lds_n, rw;

  m68k_bus_queue #(.ADDR_W(24), .REQ_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYC(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mc_rise(mc_rise), .mc_fall(mc_fall),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
    .req_read(req_read), .req_fc(req_fc), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .busy(busy), .nDTACK(nDTACK), .nBERR(nBERR), .D_IN(D_IN),
    .A_OUT(A_OUT), .FC_OUT(FC_OUT), .D_OUT(D_OUT), .a_oe(a_oe), .d_oe(d_oe),
    .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw));

  always #5 sys_clk = ~sys_clk;

  // CLK_7M model: 16 sys_clk period, rise at phase 0, fall at phase 8.
  int mc_ph;
  initial begin
    mc_ph = 0;
    forever begin
      @(posedge sys_clk);
      #1;
      mc_rise = (mc_ph == 0);
      mc_fall = (mc_ph == 8);
      mc_ph = (mc_ph + 1) % 16;
    end
  end

  typedef struct packed {
    logic [22:0] a;
    logic [2:0]  fc;
    logic [15:0] d;
    logic        rw, u, l;
    logic [15:0] aslow;
  } cyc_t;

  cyc_t        mon_q[$];
  cyc_t        cur;
  int unsigned busy_cnt;
  logic        prev_as;

  initial begin
    prev_as = 1'b1;
    cur = '0;
    busy_cnt = 0;
    forever begin
      @(negedge sys_clk);
      if (busy) busy_cnt++;
      if (!as_n) begin
        cur.a = A_OUT; cur.fc = FC_OUT; cur.d = D_OUT;
        cur.rw = rw; cur.u = uds_n; cur.l = lds_n;
        cur.aslow = cur.aslow + 16'd1;
      end else if (!prev_as) begin
        mon_q.push_back(cur);
        cur.aslow = '0;
      end
      prev_as = as_n;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_req(input logic [23:0] a, input logic [1:0] sz, input logic rd,
                          input logic [2:0] fc, input logic [31:0] wd);
    int n;
    @(posedge sys_clk);
    #1;
    req_addr = a; req_size = sz; req_read = rd; req_fc = fc; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!req_ready && n < 2000);
    chk("req accepted", {31'h0, req_ready}, 32'd1);
    @(posedge sys_clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!rsp_valid && n < 2000);
    chk("rsp arrives", {31'h0, rsp_valid}, 32'd1);
  endtask

  task automatic pop_rsp();
    rsp_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [23:0] addr;   logic [1:0] size;  logic rd;  logic [2:0] fc;
    logic [31:0] wdata;  logic [15:0] din;  logic dtack_n;  logic berr_n;
    logic [1:0]  st;     logic [31:0] rdata;
    int          ncyc;   int busy;
    logic [22:0] a0, a1; logic [15:0] d0, d1;
    logic        u, l;   int aslow;
  } vec_t;

  vec_t vt[12];
  int   n;
  logic any_busy;
  logic [1:0] bp_st[5];

  initial begin : main
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 sys_rst_n = 1'b0;
    #2;
    chk("rst as_n", {31'h0, as_n}, 1);   chk("rst uds_n", {31'h0, uds_n}, 1);
    chk("rst lds_n", {31'h0, lds_n}, 1); chk("rst rw", {31'h0, rw}, 1);
    chk("rst a_oe", {31'h0, a_oe}, 0);   chk("rst d_oe", {31'h0, d_oe}, 0);
    chk("rst busy", {31'h0, busy}, 0);   chk("rst rsp_valid", {31'h0, rsp_valid}, 0);
    chk("rst A_OUT", {9'h0, A_OUT}, 0);  chk("rst D_OUT", {16'h0, D_OUT}, 0);
    chk("rst FC_OUT", {29'h0, FC_OUT}, 0);
    repeat (3) @(negedge sys_clk);
    chk("rst req_ready", {31'h0, req_ready}, 0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("req_ready after reset", {31'h0, req_ready}, 1);

    //        addr        sz   rd   fc    wdata         din      dtk  berr st    rdata         nc bsy  a0          a1          d0       d1       u     l    aslow
    vt[0]  = '{24'h00F000, 2'd2, 1'b1, 3'd5, 32'h0,        16'hBEEF, 1'b0, 1'b1, 2'd0, 32'h0000BEEF, 1, 64,  23'h007800, 23'h0,      16'h0,    16'h0,    1'b0, 1'b0, 32};
    vt[1]  = '{24'h000100, 2'd3, 1'b0, 3'd1, 32'h12345678, 16'h0,    1'b0, 1'b1, 2'd0, 32'h0,        2, 128, 23'h000080, 23'h000081, 16'h1234, 16'h5678, 1'b0, 1'b0, 32};
    vt[2]  = '{24'h000003, 2'd1, 1'b1, 3'd2, 32'h0,        16'hAA55, 1'b0, 1'b1, 2'd0, 32'h00000055, 1, 64,  23'h000001, 23'h0,      16'h0,    16'h0,    1'b1, 1'b0, 32};
    vt[3]  = '{24'h000004, 2'd1, 1'b1, 3'd2, 32'h0,        16'hAA55, 1'b0, 1'b1, 2'd0, 32'h000000AA, 1, 64,  23'h000002, 23'h0,      16'h0,    16'h0,    1'b0, 1'b1, 32};
    vt[4]  = '{24'h000005, 2'd1, 1'b0, 3'd1, 32'hFFFFFFC3, 16'h0,    1'b0, 1'b1, 2'd0, 32'h0,        1, 64,  23'h000002, 23'h0,      16'hC3C3, 16'h0,    1'b1, 1'b0, 32};
    vt[5]  = '{24'h000200, 2'd3, 1'b1, 3'd6, 32'h0,        16'h1357, 1'b1, 1'b0, 2'd1, 32'h0,        1, 64,  23'h000100, 23'h0,      16'h0,    16'h0,    1'b0, 1'b0, 32};
    vt[6]  = '{24'h000300, 2'd3, 1'b1, 3'd6, 32'h0,        16'h1357, 1'b1, 1'b1, 2'd2, 32'h0,        1, 176, 23'h000180, 23'h0,      16'h0,    16'h0,    1'b0, 1'b0, 144};
    vt[7]  = '{24'h000400, 2'd3, 1'b1, 3'd5, 32'h0,        16'hCAFE, 1'b0, 1'b1, 2'd0, 32'hCAFECAFE, 2, 128, 23'h000200, 23'h000201, 16'h0,    16'h0,    1'b0, 1'b0, 32};
    vt[8]  = '{24'h000011, 2'd2, 1'b1, 3'd5, 32'h0,        16'h0,    1'b0, 1'b1, 2'd3, 32'h0,        0, 0,   23'h0,      23'h0,      16'h0,    16'h0,    1'b0, 1'b0, 0};
    vt[9]  = '{24'hFFFFFE, 2'd3, 1'b1, 3'd7, 32'h0,        16'h0F0F, 1'b0, 1'b1, 2'd0, 32'h0F0F0F0F, 2, 128, 23'h7FFFFF, 23'h000000, 16'h0,    16'h0,    1'b0, 1'b0, 32};
    vt[10] = '{24'h000006, 2'd0, 1'b0, 3'd1, 32'h0000005A, 16'h0,    1'b0, 1'b1, 2'd0, 32'h0,        1, 64,  23'h000003, 23'h0,      16'h5A5A, 16'h0,    1'b0, 1'b1, 32};
    vt[11] = '{24'h000008, 2'd2, 1'b0, 3'd1, 32'h0000ABCD, 16'h0,    1'b0, 1'b0, 2'd1, 32'h0,        1, 64,  23'h000004, 23'h0,      16'hABCD, 16'h0,    1'b0, 1'b0, 32};

    for (int i = 0; i < 12; i++) begin
      nDTACK = vt[i].dtack_n; nBERR = vt[i].berr_n; D_IN = vt[i].din;
      repeat (4) @(negedge sys_clk);
      mon_q.delete();
      busy_cnt = 0;
      push_req(vt[i].addr, vt[i].size, vt[i].rd, vt[i].fc, vt[i].wdata);
      wait_rsp(n);
      if (vt[i].ncyc == 0) chk($sformatf("v%0d misaligned latency", i), n, 2);
      chk($sformatf("v%0d status", i), {30'h0, rsp_status}, {30'h0, vt[i].st});
      if (vt[i].st == 2'd0) chk($sformatf("v%0d rdata", i), rsp_rdata, vt[i].rdata);
      pop_rsp();
      chk($sformatf("v%0d busy sysclks", i), busy_cnt, vt[i].busy);
      chk($sformatf("v%0d bus cycles", i), mon_q.size(), vt[i].ncyc);
      for (int j = 0; j < vt[i].ncyc && j < mon_q.size(); j++) begin
        chk($sformatf("v%0d c%0d A_OUT", i, j), {9'h0, mon_q[j].a}, {9'h0, (j == 0) ? vt[i].a0 : vt[i].a1});
        chk($sformatf("v%0d c%0d FC_OUT", i, j), {29'h0, mon_q[j].fc}, {29'h0, vt[i].fc});
        chk($sformatf("v%0d c%0d rw", i, j), {31'h0, mon_q[j].rw}, {31'h0, vt[i].rd});
        chk($sformatf("v%0d c%0d uds_n", i, j), {31'h0, mon_q[j].u}, {31'h0, vt[i].u});
        chk($sformatf("v%0d c%0d lds_n", i, j), {31'h0, mon_q[j].l}, {31'h0, vt[i].l});
        chk($sformatf("v%0d c%0d as_n low", i, j), {16'h0, mon_q[j].aslow}, vt[i].aslow);
        if (!vt[i].rd)
          chk($sformatf("v%0d c%0d D_OUT", i, j), {16'h0, mon_q[j].d}, {16'h0, (j == 0) ? vt[i].d0 : vt[i].d1});
      end
    end

    // Backpressure: responses held, four reads fill the queue, misaligned waits for space.
    nDTACK = 1'b0; nBERR = 1'b1; D_IN = 16'h2468;
    repeat (4) @(negedge sys_clk);
    mon_q.delete();
    for (int k = 0; k < 4; k++) push_req(24'h000010 + 24'(2 * k), 2'd2, 1'b1, 3'd5, 32'h0);
    @(negedge sys_clk);
    chk("bp req_ready full", {31'h0, req_ready}, 0);
    push_req(24'h000001, 2'd2, 1'b1, 3'd5, 32'h0);
    n = 0;
    while (!(mon_q.size() == 4 && !busy) && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (200) @(negedge sys_clk);
    chk("bp stalled busy", {31'h0, busy}, 0);
    chk("bp bus cycles", mon_q.size(), 4);
    chk("bp rsp_valid", {31'h0, rsp_valid}, 1);
    bp_st = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
    for (int k = 0; k < 5; k++) begin
      wait_rsp(n);
      chk($sformatf("bp r%0d status", k), {30'h0, rsp_status}, {30'h0, bp_st[k]});
      if (bp_st[k] == 2'd0) chk($sformatf("bp r%0d rdata", k), rsp_rdata, 32'h00002468);
      pop_rsp();
    end
    repeat (3) @(negedge sys_clk);
    chk("bp drained", {31'h0, rsp_valid}, 0);

    // Reset while a write sits in WAIT with two more requests queued.
    nDTACK = 1'b1; nBERR = 1'b1;
    repeat (4) @(negedge sys_clk);
    push_req(24'h000020, 2'd2, 1'b0, 3'd1, 32'h00005555);
    push_req(24'h000022, 2'd2, 1'b1, 3'd5, 32'h0);
    push_req(24'h000024, 2'd2, 1'b1, 3'd5, 32'h0);
    n = 0;
    while (as_n && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (30) @(negedge sys_clk);
    chk("wait d_oe", {31'h0, d_oe}, 1);
    chk("wait uds_n", {31'h0, uds_n}, 0);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async as_n", {31'h0, as_n}, 1);   chk("async uds_n", {31'h0, uds_n}, 1);
    chk("async lds_n", {31'h0, lds_n}, 1); chk("async rw", {31'h0, rw}, 1);
    chk("async a_oe", {31'h0, a_oe}, 0);   chk("async d_oe", {31'h0, d_oe}, 0);
    repeat (3) @(negedge sys_clk);
    chk("mid rst req_ready", {31'h0, req_ready}, 0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("post rst req_ready", {31'h0, req_ready}, 1);
    chk("post rst rsp_valid", {31'h0, rsp_valid}, 0);
    any_busy = 1'b0;
    repeat (100) begin
      @(negedge sys_clk);
      if (busy) any_busy = 1'b1;
    end
    chk("post rst queue discarded", {31'h0, any_busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
